// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Load/store alignment unit sitting between the EX/MEM pipeline register and
//   a word-organised data memory.  Byte-addressed RV32 loads and stores are
//   turned into word-aligned dmem accesses carrying a byte-lane mask.  Halfword
//   and word accesses that straddle a word boundary are split into two aligned
//   accesses while the upstream request is stalled.  Load data is merged across
//   the one or two returned words, shifted down and sign/zero-extended before
//   being handed to writeback.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_valid      request valid            o_ready      request accepted when both high
//   i_addr       byte address             i_wdata      store data (low bits)
//   i_we         1 = store, 0 = load      i_funct3     RV32 load/store funct3
//   i_rd         load destination
//   o_mem_addr   word-aligned dmem address
//   o_mem_wdata  lane-shifted store data
//   o_mem_we     dmem write enable        o_mem_type   dmem byte mask
//   i_mem_rdata  dmem read data, one cycle after the address
//   o_wb_valid   one-cycle pulse, o_wb_rd/o_wb_data valid
//   o_wb_rd      destination register     o_wb_data    extended load result
//   o_illegal    one-cycle pulse, unsupported funct3, request dropped
// -----------------------------------------------------------------------------
module lsu_align #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_BYTES = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_we,
    input  logic [2:0]            i_funct3,
    input  logic [4:0]            i_rd,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_we,
    output logic [DATA_BYTES-1:0] o_mem_type,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_wb_valid,
    output logic [4:0]            o_wb_rd,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic                  o_illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC1 = 2'd1;
    localparam logic [1:0] S_ACC2 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [4:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  illegal_q, illegal_d;

    // ------------------------------------------------------------------
    // Request decode (incoming and latched)
    // ------------------------------------------------------------------
    logic req_illegal;
    logic accept;

    // Loads accept 000/001/010/100/101; stores accept 000/001/010.
    always_comb begin
        if (i_we) begin
            req_illegal = i_funct3[2] | (i_funct3[1:0] == 2'b11);
        end else begin
            req_illegal = (i_funct3[1:0] == 2'b11) | (i_funct3 == 3'b110);
        end
    end

    assign o_ready = (state_q == S_IDLE);
    assign accept  = i_valid & o_ready;

    logic [1:0]            off;
    logic [DATA_BYTES-1:0] size_mask;
    logic                  split;

    assign off = addr_q[1:0];

    always_comb begin
        case (f3_q[1:0])
            2'b00:   size_mask = DATA_BYTES'(4'b0001);
            2'b01:   size_mask = DATA_BYTES'(4'b0011);
            default: size_mask = DATA_BYTES'(4'b1111);
        endcase
    end

    assign split = ((f3_q[1:0] == 2'b01) && (off == 2'd3)) ||
                   ((f3_q[1:0] == 2'b10) && (off != 2'd0));

    // Shifting the mask and data into a double-width window gives both
    // accesses at once: the low half is access 1, the high half is what
    // spills into the next word (access 2).
    logic [2*DATA_BYTES-1:0] lane_mask;
    logic [2*DATA_WIDTH-1:0] lane_wdata;

    assign lane_mask  = {{DATA_BYTES{1'b0}}, size_mask} << off;
    assign lane_wdata = {{DATA_WIDTH{1'b0}}, wdata_q} << {off, 3'b000};

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [ADDR_WIDTH-1:0] next_word_addr;

    assign word_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign next_word_addr = word_addr + ADDR_WIDTH'(4);   // wraps at the top

    // ------------------------------------------------------------------
    // Load merge and extension (used in RESP)
    // ------------------------------------------------------------------
    logic [2*DATA_WIDTH-1:0] load_pair;
    logic [DATA_WIDTH-1:0]   load_word;
    logic [DATA_WIDTH-1:0]   load_ext;

    // In RESP, i_mem_rdata holds the last word read; for a split load the
    // first word was parked in rdata1_q during ACC2.
    assign load_pair = split ? {i_mem_rdata, rdata1_q}
                             : {{DATA_WIDTH{1'b0}}, i_mem_rdata};
    assign load_word = DATA_WIDTH'(load_pair >> {off, 3'b000});

    always_comb begin
        case (f3_q[1:0])
            2'b00:   load_ext = {{(DATA_WIDTH-8){~f3_q[2] & load_word[7]}},
                                 load_word[7:0]};
            2'b01:   load_ext = {{(DATA_WIDTH-16){~f3_q[2] & load_word[15]}},
                                 load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    // ------------------------------------------------------------------
    // dmem drive
    // ------------------------------------------------------------------
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_we    = 1'b0;
        o_mem_type  = '0;
        case (state_q)
            S_ACC1: begin
                o_mem_addr  = word_addr;
                o_mem_wdata = lane_wdata[DATA_WIDTH-1:0];
                o_mem_we    = we_q;
                o_mem_type  = lane_mask[DATA_BYTES-1:0];
            end
            S_ACC2: begin
                o_mem_addr  = next_word_addr;
                o_mem_wdata = lane_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
                o_mem_we    = we_q;
                o_mem_type  = lane_mask[2*DATA_BYTES-1:DATA_BYTES];
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM and datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        rdata1_d   = rdata1_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        illegal_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_illegal) begin
                        illegal_d = 1'b1;
                    end else begin
                        addr_d  = i_addr;
                        wdata_d = i_wdata;
                        we_d    = i_we;
                        f3_d    = i_funct3;
                        rd_d    = i_rd;
                        state_d = S_ACC1;
                    end
                end
            end
            S_ACC1: begin
                if (split)      state_d = S_ACC2;
                else if (!we_q) state_d = S_RESP;
                else            state_d = S_IDLE;
            end
            S_ACC2: begin
                rdata1_d = i_mem_rdata;
                state_d  = we_q ? S_IDLE : S_RESP;
            end
            default: begin  // S_RESP
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = load_ext;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            rd_q       <= '0;
            rdata1_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            rdata1_q   <= rdata1_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
        end
    end

    assign o_wb_valid = wb_valid_q;
    assign o_wb_rd    = wb_rd_q;
    assign o_wb_data  = wb_data_q;
    assign o_illegal  = illegal_q;

endmodule
